// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD constants and BCD pair helpers
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [4*DIGIT_W-1:0] BCD_ZERO = '0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

    // Two-digit BCD encoding of a value 0..99
    function automatic logic [2*DIGIT_W-1:0] bcd_of(input int n);
        return {DIGIT_W'(n / 10), DIGIT_W'(n % 10)};
    endfunction

    // Next value of a BCD pair that wraps to 00 after reaching last
    function automatic logic [2*DIGIT_W-1:0] bcd_pair_inc(input logic [2*DIGIT_W-1:0] v,
                                                          input logic [2*DIGIT_W-1:0] last);
        return (v == last) ? '0 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter modulo MOD
//   clk_pll, rst : clock and synchronous active-high reset
//   clr          : synchronous zero
//   inc          : advance by one
//   bcd          : {tens, units}
//   carry        : inc while at MOD-1 (combinational)
module bcd_digit_pair
    import stopwatch_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       clk_pll,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd,
    output logic       carry
);

    localparam logic [7:0] LAST = bcd_of(MOD - 1);

    assign carry = inc && (bcd == LAST);

    always_ff @(posedge clk_pll) begin
        if (rst || clr)
            bcd <= '0;
        else if (inc)
            bcd <= bcd_pair_inc(bcd, LAST);
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS BCD stopwatch with start/stop, clear and lap hold
//   clk_pll    : only clock
//   rst        : synchronous active-high reset
//   tick_in    : 1 Hz divider tick, one cycle wide
//   start_stop : start / pause / resume pulse
//   clear      : return to IDLE and zero count and lap
//   lap        : toggle lap hold (RUN or PAUSE only)
//   digits_o   : {min_tens, min_units, sec_tens, sec_units}
//   running    : high in RUN
//   lap_hold   : high while digits_o shows the lap value
//   rollover   : one-cycle pulse on wrap to 00:00
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60
) (
    input  logic        clk_pll,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits_o,
    output logic        running,
    output logic        lap_hold,
    output logic        rollover
);

    localparam logic [7:0] SEC_LAST = bcd_of(SEC_MOD - 1);
    localparam logic [7:0] MIN_LAST = bcd_of(MIN_MOD - 1);

    state_t      state, state_nxt;
    logic [7:0]  sec_bcd, min_bcd, sec_nxt, min_nxt;
    logic        sec_inc, sec_carry, min_carry, lap_go, lap_hold_nxt;
    logic [15:0] count, count_nxt, lap_reg, lap_reg_nxt;

    assign sec_inc = (state == ST_RUN) && tick_in && !clear;
    assign count   = {min_bcd, sec_bcd};
    assign lap_go  = lap && (state != ST_IDLE);

    bcd_digit_pair #(.MOD(SEC_MOD)) u_sec (
        .clk_pll(clk_pll),
        .rst    (rst),
        .clr    (clear),
        .inc    (sec_inc),
        .bcd    (sec_bcd),
        .carry  (sec_carry)
    );

    bcd_digit_pair #(.MOD(MIN_MOD)) u_min (
        .clk_pll(clk_pll),
        .rst    (rst),
        .clr    (clear),
        .inc    (sec_carry),
        .bcd    (min_bcd),
        .carry  (min_carry)
    );

    // Next-cycle view of the counters, so the output mux can be registered
    // without adding a cycle of latency behind the pair registers.
    always_comb begin
        sec_nxt      = sec_inc ? bcd_pair_inc(sec_bcd, SEC_LAST) : sec_bcd;
        min_nxt      = sec_carry ? bcd_pair_inc(min_bcd, MIN_LAST) : min_bcd;
        count_nxt    = clear ? BCD_ZERO : {min_nxt, sec_nxt};
        lap_hold_nxt = clear ? 1'b0 : lap_go ? !lap_hold : lap_hold;
        lap_reg_nxt  = clear ? BCD_ZERO : (lap_go && !lap_hold) ? count : lap_reg;
        state_nxt    = clear ? ST_IDLE :
                       start_stop ? ((state == ST_RUN) ? ST_PAUSE : ST_RUN) : state;
    end

    always_ff @(posedge clk_pll) begin
        if (rst) begin
            state    <= ST_IDLE;
            lap_reg  <= BCD_ZERO;
            lap_hold <= 1'b0;
            running  <= 1'b0;
            rollover <= 1'b0;
            digits_o <= BCD_ZERO;
        end else begin
            state    <= state_nxt;
            lap_reg  <= lap_reg_nxt;
            lap_hold <= lap_hold_nxt;
            running  <= (state_nxt == ST_RUN);
            rollover <= min_carry;
            digits_o <= lap_hold_nxt ? lap_reg_nxt : count_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed checks of bcd_stopwatch at 60/60 and 10/2 moduli
module tb_bcd_stopwatch;

    logic        clk = 0;
    logic        rst = 1;
    logic        tick_a = 0, ss_a = 0, clr_a = 0, lap_a = 0;
    logic        tick_b = 0, ss_b = 0, clr_b = 0, lap_b = 0;
    logic [15:0] dig_a, dig_b;
    logic        run_a, run_b, hold_a, hold_b, roll_a, roll_b;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    bcd_stopwatch u_a (
        .clk_pll(clk), .rst(rst), .tick_in(tick_a), .start_stop(ss_a), .clear(clr_a),
        .lap(lap_a), .digits_o(dig_a), .running(run_a), .lap_hold(hold_a), .rollover(roll_a)
    );

    bcd_stopwatch #(.SEC_MOD(10), .MIN_MOD(2)) u_b (
        .clk_pll(clk), .rst(rst), .tick_in(tick_b), .start_stop(ss_b), .clear(clr_b),
        .lap(lap_b), .digits_o(dig_b), .running(run_b), .lap_hold(hold_b), .rollover(roll_b)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [15:0] d, input int sm, input int mm);
        int s, m;
        s = int'(d[7:4]) * 10 + int'(d[3:0]);
        m = int'(d[15:12]) * 10 + int'(d[11:8]);
        return d[3:0] <= 9 && d[7:4] <= 9 && d[11:8] <= 9 && d[15:12] <= 9 && s < sm && m < mm;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("legal_a", 16'(legal(dig_a, 60, 60)), 16'd1);
            chk("legal_b", 16'(legal(dig_b, 10, 2)), 16'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input bit b);
        if (b) tick_b = 1; else tick_a = 1;
        repeat (n) cyc();
        tick_a = 0;
        tick_b = 0;
    endtask

    initial begin
        cyc(); cyc();
        rst = 0;
        chk("rst_digits", dig_a, 16'h0000);
        chk("rst_running", 16'(run_a), 16'd0);
        chk("rst_hold", 16'(hold_a), 16'd0);
        chk("rst_roll", 16'(roll_a), 16'd0);

        // lap is ignored in IDLE
        lap_a = 1; cyc(); lap_a = 0;
        chk("idle_lap", 16'(hold_a), 16'd0);

        // 1: start, 75 ticks
        ss_a = 1; cyc(); ss_a = 0;
        chk("start_run", 16'(run_a), 16'd1);
        ticks(75, 0);
        chk("t1_digits", dig_a, 16'h0115);
        chk("t1_roll", 16'(roll_a), 16'd0);

        // 2: up to 59:58, then wrap
        ticks(3523, 0);
        chk("t2_5958", dig_a, 16'h5958);
        ticks(1, 0);
        chk("t2_5959", dig_a, 16'h5959);
        chk("t2_roll0", 16'(roll_a), 16'd0);
        ticks(1, 0);
        chk("t2_wrap", dig_a, 16'h0000);
        chk("t2_roll1", 16'(roll_a), 16'd1);
        cyc();
        chk("t2_roll_drop", 16'(roll_a), 16'd0);

        // 3: pause coincident with a tick
        ticks(10, 0);
        chk("t3_0010", dig_a, 16'h0010);
        ss_a = 1; tick_a = 1; cyc(); ss_a = 0; tick_a = 0;
        chk("t3_pause_digits", dig_a, 16'h0011);
        chk("t3_pause_run", 16'(run_a), 16'd0);
        ticks(5, 0);
        chk("t3_paused", dig_a, 16'h0011);
        ss_a = 1; cyc(); ss_a = 0;
        chk("t3_resume", 16'(run_a), 16'd1);
        ticks(1, 0);
        chk("t3_0012", dig_a, 16'h0012);

        // 4: lap hold at 00:20
        ticks(8, 0);
        chk("t4_0020", dig_a, 16'h0020);
        lap_a = 1; cyc(); lap_a = 0;
        chk("t4_hold", 16'(hold_a), 16'd1);
        ticks(3, 0);
        chk("t4_frozen", dig_a, 16'h0020);
        lap_a = 1; cyc(); lap_a = 0;
        chk("t4_release", dig_a, 16'h0023);
        chk("t4_hold0", 16'(hold_a), 16'd0);

        // lap capture coincident with a tick takes the pre-increment count
        ticks(3, 0);
        lap_a = 1; tick_a = 1; cyc(); lap_a = 0; tick_a = 0;
        chk("lap_tick_digits", dig_a, 16'h0026);
        lap_a = 1; cyc(); lap_a = 0;
        chk("lap_tick_release", dig_a, 16'h0027);

        // 5: clear with lap held at 12:34, coincident with a tick
        clr_a = 1; cyc(); clr_a = 0;
        chk("t5_clr", dig_a, 16'h0000);
        chk("t5_clr_run", 16'(run_a), 16'd0);
        ss_a = 1; cyc(); ss_a = 0;
        ticks(754, 0);
        chk("t5_1234", dig_a, 16'h1234);
        lap_a = 1; cyc(); lap_a = 0;
        chk("t5_hold", 16'(hold_a), 16'd1);
        clr_a = 1; tick_a = 1; cyc(); clr_a = 0; tick_a = 0;
        chk("t5_digits", dig_a, 16'h0000);
        chk("t5_running", 16'(run_a), 16'd0);
        chk("t5_hold0", 16'(hold_a), 16'd0);
        ticks(5, 0);
        chk("t5_idle", dig_a, 16'h0000);

        // 6: small moduli
        ss_b = 1; cyc(); ss_b = 0;
        ticks(9, 1);
        chk("t6_0009", dig_b, 16'h0009);
        ticks(1, 1);
        chk("t6_0100", dig_b, 16'h0100);
        ticks(9, 1);
        chk("t6_0109", dig_b, 16'h0109);
        chk("t6_roll0", 16'(roll_b), 16'd0);
        ticks(1, 1);
        chk("t6_wrap", dig_b, 16'h0000);
        chk("t6_roll1", 16'(roll_b), 16'd1);
        cyc();
        chk("t6_roll_drop", 16'(roll_b), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
